// File: rtl/param_lifo.sv
// ============================================================================
// Module   : param_lifo
// Desc     : Parametrised LIFO stack with registered pop output, replace-top
//            push+pop, synchronous flush and sticky error flags.
//            Optional almost-full/empty outputs under LIFO_ALMOST_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_lifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
`ifdef LIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_TH  = DEPTH - 1,
   parameter int AE_TH  = 1
`endif
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              push,
   input  logic                              pop,
   input  logic                              flush,
   input  logic                              clr_err,
   input  logic [DATA_W-1:0]                 data_in,
   output logic [DATA_W-1:0]                 data_out,
   output logic                              out_valid,
   output logic [DATA_W-1:0]                 top,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic                              empty,
   output logic                              full,
   output logic                              overflow,
   output logic                              underflow
`ifdef LIFO_ALMOST_FLAGS_EN
   ,
   output logic                              almost_full,
   output logic                              almost_empty
`endif
);

   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam int               IDX_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  top_cnt;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  wr_idx;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign top_cnt = count - 1'b1;
   assign top_idx = top_cnt[IDX_W-1:0];
   assign top     = empty ? '0 : mem[top_idx];

   // Replace-top writes over the current top; a plain push writes one above it.
   assign wr_idx  = pop ? top_idx : count[IDX_W-1:0];

`ifdef LIFO_ALMOST_FLAGS_EN
   assign almost_full  = (count >= CNT_W'(AF_TH));
   assign almost_empty = (count <= CNT_W'(AE_TH));
`endif

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!flush && push) begin
         if ((pop && !empty) || (!pop && !full)) begin
            mem[wr_idx] <= data_in;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         // Error sets below override this clear within the same cycle.
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (flush) begin
            count <= '0;
         end else if (push && pop) begin
            out_valid <= 1'b1;
            data_out  <= empty ? data_in : top;
         end else if (push) begin
            if (full) begin
               overflow <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end else if (pop) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               data_out  <= top;
               out_valid <= 1'b1;
               count     <= count - 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire
